// File: rtl/pll_reset_seq.sv
// Reset sequencer for the PLL clock domain: waits for a stable, synchronised
// lock, then releases the system reset and, after a further delay, the CPU reset.
module pll_reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int CPU_DELAY   = 256,
    parameter int CNT_W       = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       cpu_reset_req,
    output logic       sys_reset_n,
    output logic       cpu_reset_n,
    output logic       lock_lost,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        CPU_WAIT  = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lost_q, lost_d;
    logic                   sys_q, cpu_q;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Loss of synchronised lock is checked first in every state, so it
    // always wins over a pending CPU re-reset request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = CPU_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CPU_WAIT: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost_d  = 1'b1;
                end else if (cpu_reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CPU_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    lost_d  = 1'b1;
                end else if (cpu_reset_req) begin
                    state_d = CPU_WAIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Reset outputs are registered from the next state so they move on the
    // same edge as seq_state.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
            sys_q   <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
            sys_q   <= (state_d == CPU_WAIT) || (state_d == RUN);
            cpu_q   <= (state_d == RUN);
        end
    end

    assign sys_reset_n = sys_q;
    assign cpu_reset_n = cpu_q;
    assign lock_lost   = lost_q;
    assign seq_state   = state_q;

endmodule
